// File: rtl/control_pipeline.sv
// Control pipeline: carries decoded control bits through EX/MEM/WB, resolves hazards,
// taken branches and data-memory handshakes. Optional operand forwarding: CONTROL_PIPELINE_FORWARDING_EN.
module control_pipeline #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       idValid,
  input  logic [8:0] idCtrl,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic [4:0] idRd,
  input  logic       aluZero,
  input  logic       memReady,
  output logic       stallOut,
  output logic       flushOut,
  output logic       pcSrc,
  output logic [1:0] exAluOp,
  output logic       exAluSrc,
  output logic       memReq,
  output logic       memWe,
  output logic       memError,
  output logic       wbRegWrite,
  output logic       wbMemToReg,
  output logic [4:0] wbDest,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  typedef struct packed {
    logic       reg_dest;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } id_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [4:0] dest;
  } ex_stage_t;

  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] dest;
  } mem_stage_t;

  typedef struct packed {
    logic       valid;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] dest;
  } wb_stage_t;

  id_ctrl_t   id_ctrl;
  ex_stage_t  ex_q, ex_d;
  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q, wb_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic mem_req, timeout, mem_stall;
  logic load_use, hazard, hazard_stall, branch_taken;

  assign id_ctrl = id_ctrl_t'(idCtrl);

  function automatic logic dest_hit(input logic [4:0] dest, input logic [4:0] rs,
                                    input logic [4:0] rt);
    return (dest != 5'd0) && ((dest == rs) || (dest == rt));
  endfunction

  // Data-memory handshake: the final waiting cycle aborts instead of stalling.
  assign mem_req   = mem_q.valid & (mem_q.mem_read | mem_q.mem_write);
  assign timeout   = mem_req & ~memReady & (wait_cnt_q == CNT_W'(MEM_WAIT_MAX - 1));
  assign mem_stall = mem_req & ~memReady & ~timeout;

  assign load_use = idValid & ex_q.valid & ex_q.mem_read & ex_q.reg_write
                  & dest_hit(ex_q.dest, idRs, idRt);

`ifdef CONTROL_PIPELINE_FORWARDING_EN
  logic [4:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;

  assign hazard = load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input mem_stage_t m,
                                         input wb_stage_t w);
    if (m.valid && m.reg_write && m.dest != 5'd0 && m.dest == src) return 2'b10;
    if (w.valid && w.reg_write && w.dest != 5'd0 && w.dest == src) return 2'b01;
    return 2'b00;
  endfunction

  assign forwardA = ex_q.valid ? fwd_sel(ex_rs_q, mem_q, wb_q) : 2'b00;
  assign forwardB = ex_q.valid ? fwd_sel(ex_rt_q, mem_q, wb_q) : 2'b00;
`else
  // Without forwarding any pending EX/MEM writer of a source blocks issue until it reaches WB.
  assign hazard = load_use
                | (idValid & ex_q.valid  & ex_q.reg_write  & dest_hit(ex_q.dest,  idRs, idRt))
                | (idValid & mem_q.valid & mem_q.reg_write & dest_hit(mem_q.dest, idRs, idRt));
  assign forwardA = 2'b00;
  assign forwardB = 2'b00;
`endif

  assign branch_taken = ex_q.valid & ex_q.branch & aluZero & ~mem_stall;
  assign hazard_stall = hazard & ~branch_taken;

  // NOTE: every variable assigned here gets a default first, so no path infers a latch.
  always_comb begin : stage_next
    ex_d       = ex_q;
    mem_d      = mem_q;
    wb_d       = wb_q;
    wait_cnt_d = '0;
`ifdef CONTROL_PIPELINE_FORWARDING_EN
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
`endif
    if (mem_stall) begin
      wb_d       = '0;
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wb_d.valid      = mem_q.valid;
      wb_d.mem_to_reg = mem_q.mem_to_reg;
      wb_d.reg_write  = mem_q.reg_write & ~timeout;
      wb_d.dest       = mem_q.dest;

      mem_d.valid      = ex_q.valid;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.dest       = ex_q.dest;

      ex_d = '0;
`ifdef CONTROL_PIPELINE_FORWARDING_EN
      ex_rs_d = '0;
      ex_rt_d = '0;
`endif
      if (idValid && !hazard_stall && !branch_taken) begin
        ex_d.valid      = 1'b1;
        ex_d.branch     = id_ctrl.branch;
        ex_d.mem_read   = id_ctrl.mem_read;
        ex_d.mem_to_reg = id_ctrl.mem_to_reg;
        ex_d.alu_op     = id_ctrl.alu_op;
        ex_d.mem_write  = id_ctrl.mem_write;
        ex_d.alu_src    = id_ctrl.alu_src;
        ex_d.reg_write  = id_ctrl.reg_write;
        ex_d.dest       = id_ctrl.reg_dest ? idRd : idRt;
`ifdef CONTROL_PIPELINE_FORWARDING_EN
        ex_rs_d = idRs;
        ex_rt_d = idRt;
`endif
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      wait_cnt_q <= '0;
`ifdef CONTROL_PIPELINE_FORWARDING_EN
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
`endif
    end else begin
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef CONTROL_PIPELINE_FORWARDING_EN
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
`endif
    end
  end

  assign stallOut   = mem_stall | hazard_stall;
  assign flushOut   = branch_taken;
  assign pcSrc      = branch_taken;
  assign exAluOp    = ex_q.valid ? ex_q.alu_op : 2'b00;
  assign exAluSrc   = ex_q.valid & ex_q.alu_src;
  assign memReq     = mem_req;
  assign memWe      = mem_req & mem_q.mem_write;
  assign memError   = timeout;
  assign wbRegWrite = wb_q.valid & wb_q.reg_write & (wb_q.dest != 5'd0);
  assign wbMemToReg = wb_q.valid & wb_q.mem_to_reg;
  assign wbDest     = wb_q.valid ? wb_q.dest : 5'd0;

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: scoreboard of expected write-backs plus per-scenario checks.
module tb_control_pipeline;

  localparam int WAIT_MAX = 15;
  localparam logic [8:0] C_RTYPE = 9'b100010001;
  localparam logic [8:0] C_LW    = 9'b001100011;
  localparam logic [8:0] C_SW    = 9'b000000110;
  localparam logic [8:0] C_BEQ   = 9'b010001000;

`ifdef CONTROL_PIPELINE_FORWARDING_EN
  localparam int         EXP_LU_STALLS = 1;
  localparam logic [1:0] EXP_LU_FWD_A  = 2'b01;
`else
  localparam int         EXP_LU_STALLS = 2;
  localparam logic [1:0] EXP_LU_FWD_A  = 2'b00;
`endif

  logic       clock, resetN, idValid, aluZero, memReady;
  logic [8:0] idCtrl;
  logic [4:0] idRs, idRt, idRd;
  logic       stallOut, flushOut, pcSrc, exAluSrc, memReq, memWe, memError;
  logic       wbRegWrite, wbMemToReg;
  logic [1:0] exAluOp, forwardA, forwardB;
  logic [4:0] wbDest;
  logic [19:0] all_out;

  typedef struct {
    logic [4:0] dest;
    logic       m2r;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  control_pipeline #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clock(clock), .resetN(resetN), .idValid(idValid), .idCtrl(idCtrl),
    .idRs(idRs), .idRt(idRt), .idRd(idRd), .aluZero(aluZero), .memReady(memReady),
    .stallOut(stallOut), .flushOut(flushOut), .pcSrc(pcSrc), .exAluOp(exAluOp),
    .exAluSrc(exAluSrc), .memReq(memReq), .memWe(memWe), .memError(memError),
    .wbRegWrite(wbRegWrite), .wbMemToReg(wbMemToReg), .wbDest(wbDest),
    .forwardA(forwardA), .forwardB(forwardB)
  );

  assign all_out = {stallOut, flushOut, pcSrc, exAluOp, exAluSrc, memReq, memWe, memError,
                    wbRegWrite, wbMemToReg, wbDest, forwardA, forwardB};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every register-file write must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (resetN && wbRegWrite) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected got dest=%0d want no write-back", wbDest);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        if (wbDest !== e.dest || wbMemToReg !== e.m2r) begin
          bad++;
          $display("FAIL wb_order got dest=%0d m2r=%0b want dest=%0d m2r=%0b",
                   wbDest, wbMemToReg, e.dest, e.m2r);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [8:0] c, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd);
    idValid = v; idCtrl = c; idRs = rs; idRt = rt; idRd = rd;
  endtask

  task automatic push_wb(input logic [4:0] dest, input logic m2r);
    wb_exp_t e;
    e.dest = dest;
    e.m2r  = m2r;
    exp_q.push_back(e);
  endtask

  // Presents one instruction and holds it (as IF/ID would) until the block accepts it.
  task automatic issue(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, output int stalls);
    stalls = 0;
    drive_id(1'b1, c, rs, rt, rd);
    @(negedge clock);
    while (stallOut && stalls < 40) begin
      stalls++;
      @(negedge clock);
    end
    if (stallOut) begin
      total++;
      bad++;
      $display("FAIL issue_bound got stall>%0d cycles want release", stalls);
    end
    tick();
    drive_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic drain(input string name);
    repeat (5) tick();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_drain got %0d pending write-backs want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (all_out !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs got %0h want 0", all_out);
    end
    repeat (2) tick();
    resetN = 1'b1;
    @(negedge clock);
    total++;
    if (all_out !== 20'd0) begin
      bad++;
      $display("FAIL reset_release got %0h want 0", all_out);
    end
    tick();
  endtask

  task automatic test_rtype();
    drive_id(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3);
    push_wb(5'd3, 1'b0);
    tick();
    drive_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    total++;
    if (exAluOp !== 2'b10 || exAluSrc !== 1'b0) begin
      bad++;
      $display("FAIL rtype_ex got aluop=%0b src=%0b want 10/0", exAluOp, exAluSrc);
    end
    tick();
    tick();
    @(negedge clock);
    total++;
    if (wbRegWrite !== 1'b1 || wbDest !== 5'd3 || wbMemToReg !== 1'b0) begin
      bad++;
      $display("FAIL rtype_wb got we=%0b dest=%0d m2r=%0b want 1/3/0",
               wbRegWrite, wbDest, wbMemToReg);
    end
    drain("rtype");
  endtask

  task automatic test_back_to_back();
    int s, sum;
    sum = 0;
    push_wb(5'd5, 1'b0); issue(C_RTYPE, 5'd1, 5'd2, 5'd5, s); sum += s;
    push_wb(5'd6, 1'b0); issue(C_RTYPE, 5'd1, 5'd2, 5'd6, s); sum += s;
    issue(C_RTYPE, 5'd1, 5'd2, 5'd0, s); sum += s;
    push_wb(5'd7, 1'b1); issue(C_LW, 5'd1, 5'd7, 5'd0, s); sum += s;
    push_wb(5'd3, 1'b0); issue(C_RTYPE, 5'd1, 5'd2, 5'd3, s); sum += s;
    total++;
    if (sum !== 0) begin
      bad++;
      $display("FAIL b2b_stalls got %0d want 0", sum);
    end
    drain("b2b");
  endtask

  task automatic test_load_use();
    int s;
    push_wb(5'd4, 1'b1);
    issue(C_LW, 5'd1, 5'd4, 5'd9, s);
    push_wb(5'd8, 1'b0);
    issue(C_RTYPE, 5'd4, 5'd2, 5'd8, s);
    total++;
    if (s !== EXP_LU_STALLS) begin
      bad++;
      $display("FAIL loaduse_stalls got %0d want %0d", s, EXP_LU_STALLS);
    end
    @(negedge clock);
    total++;
    if (forwardA !== EXP_LU_FWD_A || forwardB !== 2'b00 || exAluOp !== 2'b10) begin
      bad++;
      $display("FAIL loaduse_fwd got fa=%0b fb=%0b op=%0b want %0b/00/10",
               forwardA, forwardB, exAluOp, EXP_LU_FWD_A);
    end
    drain("loaduse");
  endtask

  task automatic test_branch();
    int s;
    issue(C_BEQ, 5'd1, 5'd2, 5'd0, s);
    aluZero = 1'b1;
    drive_id(1'b1, C_RTYPE, 5'd0, 5'd0, 5'd10);
    @(negedge clock);
    total++;
    if (pcSrc !== 1'b1 || flushOut !== 1'b1 || stallOut !== 1'b0) begin
      bad++;
      $display("FAIL branch_taken got pc=%0b fl=%0b st=%0b want 1/1/0", pcSrc, flushOut, stallOut);
    end
    tick();
    aluZero = 1'b0;
    drive_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    total++;
    if (pcSrc !== 1'b0 || flushOut !== 1'b0 || exAluOp !== 2'b00) begin
      bad++;
      $display("FAIL branch_after got pc=%0b fl=%0b op=%0b want 0/0/00", pcSrc, flushOut, exAluOp);
    end
    tick();
    issue(C_BEQ, 5'd1, 5'd2, 5'd0, s);
    push_wb(5'd11, 1'b0);
    drive_id(1'b1, C_RTYPE, 5'd0, 5'd0, 5'd11);
    @(negedge clock);
    total++;
    if (pcSrc !== 1'b0 || flushOut !== 1'b0) begin
      bad++;
      $display("FAIL branch_fallthru got pc=%0b fl=%0b want 0/0", pcSrc, flushOut);
    end
    tick();
    drive_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    drain("branch");
  endtask

  task automatic test_store_wait();
    int s, req_n, we_n, st_n, done_n;
    req_n = 0; we_n = 0; st_n = 0; done_n = 0;
    memReady = 1'b0;
    issue(C_SW, 5'd1, 5'd2, 5'd0, s);
    push_wb(5'd12, 1'b0);
    issue(C_RTYPE, 5'd0, 5'd0, 5'd12, s);
    for (int i = 0; i < 6; i++) begin
      memReady = (i == 3);
      @(negedge clock);
      if (memReq) req_n++;
      if (memWe) we_n++;
      if (stallOut) st_n++;
      if (memReq && memReady) done_n++;
      tick();
    end
    memReady = 1'b1;
    total++;
    if (req_n !== 4 || we_n !== 4 || st_n !== 3 || done_n !== 1) begin
      bad++;
      $display("FAIL store_wait got req=%0d we=%0d stall=%0d done=%0d want 4/4/3/1",
               req_n, we_n, st_n, done_n);
    end
    drain("store");
  endtask

  task automatic test_timeout();
    int s, req_n, st_n, err_n, err_at;
    req_n = 0; st_n = 0; err_n = 0; err_at = 0;
    memReady = 1'b0;
    issue(C_LW, 5'd1, 5'd5, 5'd0, s);
    tick();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (memReq) req_n++;
      if (stallOut) st_n++;
      if (memError) begin
        err_n++;
        err_at = i;
      end
      tick();
    end
    memReady = 1'b1;
    total++;
    if (err_n !== 1 || err_at !== WAIT_MAX) begin
      bad++;
      $display("FAIL timeout_err got pulses=%0d at=%0d want 1 at %0d", err_n, err_at, WAIT_MAX);
    end
    total++;
    if (req_n !== WAIT_MAX || st_n !== WAIT_MAX - 1) begin
      bad++;
      $display("FAIL timeout_req got req=%0d stall=%0d want %0d/%0d",
               req_n, st_n, WAIT_MAX, WAIT_MAX - 1);
    end
    drain("timeout");
  endtask

  task automatic test_reset_mid_access();
    int s;
    logic [19:0] seen;
    push_wb(5'd12, 1'b0);
    issue(C_RTYPE, 5'd0, 5'd0, 5'd12, s);
    issue(C_SW, 5'd1, 5'd2, 5'd0, s);
    memReady = 1'b0;
    issue(C_RTYPE, 5'd0, 5'd0, 5'd13, s);
    drive_id(1'b1, C_RTYPE, 5'd0, 5'd0, 5'd14);
    @(negedge clock);
    total++;
    if (memReq !== 1'b1 || memWe !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got req=%0b we=%0b want 1/1", memReq, memWe);
    end
    #2;
    resetN = 1'b0;
    #1;
    total++;
    if (all_out !== 20'd0) begin
      bad++;
      $display("FAIL rstmid_async got %0h want 0", all_out);
    end
    tick();
    drive_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    memReady = 1'b1;
    resetN = 1'b1;
    seen = '0;
    repeat (4) begin
      @(negedge clock);
      seen |= all_out;
      tick();
    end
    total++;
    if (seen !== 20'd0) begin
      bad++;
      $display("FAIL rstmid_empty got %0h want 0", seen);
    end
    drain("rstmid");
  endtask

  initial begin
    resetN = 1'b0;
    aluZero = 1'b0;
    memReady = 1'b1;
    drive_id(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_rtype();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_store_wait();
    test_timeout();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
